// File: rtl/inst_issuer.sv
// inst_issuer: FIFO-fed instruction issuer for the control unit; optional issued_cnt under `ISSUE_CNT_EN
module inst_issuer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int HOLD_BITS   = 8,
  parameter int DEPTH       = 16,
  parameter int IDLE_OPCODE = 0,
  localparam int INST_BITS  = OPCODE_BITS + 2 * ADDR_BITS,
  localparam int ENTRY_BITS = HOLD_BITS + INST_BITS,
  localparam int CW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  in_valid,
  input  logic [ENTRY_BITS-1:0] in_entry,
  output logic                  in_ready,
  output logic [INST_BITS-1:0]  instruction,
  output logic                  issue_strobe,
  output logic                  busy,
  output logic [CW:0]           fifo_count
`ifdef ISSUE_CNT_EN
  ,
  output logic [15:0]           issued_cnt
`endif
);
  localparam logic [INST_BITS-1:0] IDLE_INST = {OPCODE_BITS'(IDLE_OPCODE), (2 * ADDR_BITS)'(0)};
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t                state_q;
  logic [ENTRY_BITS-1:0] mem_q [DEPTH];
  logic [CW-1:0]         wr_q, rd_q;
  logic [CW:0]           count_q, count_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d, head_hold;
  logic [INST_BITS-1:0]  inst_q;
  logic                  strobe_q, busy_q, push, pop;
  // Pop only at an instruction boundary; a push on this edge is not yet visible to it
  always_comb begin
    push      = in_valid && in_ready;
    pop       = (state_q == S_IDLE || hold_q == '0) && run && count_q != '0;
    head_hold = mem_q[rd_q][ENTRY_BITS-1 -: HOLD_BITS];
    hold_d    = head_hold == '0 ? '0 : head_hold - 1'b1;
    count_d   = count_q + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  end
  assign in_ready     = count_q < (CW + 1)'(DEPTH);
  assign instruction  = inst_q;
  assign issue_strobe = strobe_q;
  assign busy         = busy_q;
  assign fifo_count   = count_q;
  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_entry;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end
  // Issue FSM: load on pop, count down the hold, fall back to idle at an empty or paused boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      inst_q   <= IDLE_INST;
      hold_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (pop) begin
      state_q  <= S_ISSUE;
      inst_q   <= mem_q[rd_q][INST_BITS-1:0];
      hold_q   <= hold_d;
      strobe_q <= 1'b1;
      busy_q   <= 1'b1;
    end else if (state_q == S_IDLE || hold_q == '0) begin
      state_q  <= S_IDLE;
      inst_q   <= IDLE_INST;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      hold_q   <= hold_q - 1'b1;
      strobe_q <= 1'b0;
    end
  end
`ifdef ISSUE_CNT_EN
  logic [15:0] issued_q;
  assign issued_cnt = issued_q;
  // Counts every issued instruction, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) issued_q <= '0;
    else if (pop) issued_q <= issued_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_inst_issuer.sv
// tb_inst_issuer: directed self-checking bench for inst_issuer
module tb_inst_issuer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        in_valid = 1'b0;
  logic [27:0] in_entry = '0;
  logic        in_ready;
  logic [19:0] instruction;
  logic        issue_strobe;
  logic        busy;
  logic [4:0]  fifo_count;
`ifdef ISSUE_CNT_EN
  logic [15:0] issued_cnt;
`endif
  int total = 0;
  int bad = 0;

  inst_issuer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .in_valid(in_valid), .in_entry(in_entry),
    .in_ready(in_ready), .instruction(instruction), .issue_strobe(issue_strobe),
    .busy(busy), .fifo_count(fifo_count)
`ifdef ISSUE_CNT_EN
    , .issued_cnt(issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input int h, input int op, input int a, input int b);
    logic [7:0] hh, aa, bb;
    logic [3:0] oo;
    hh = h[7:0]; oo = op[3:0]; aa = a[7:0]; bb = b[7:0];
    return {hh, oo, aa, bb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] inst, input logic strb, input logic bsy);
    total++;
    if (instruction !== inst || issue_strobe !== strb || busy !== bsy) begin
      bad++;
      $display("FAIL %s: got inst=%h strobe=%b busy=%b, want inst=%h strobe=%b busy=%b",
               name, instruction, issue_strobe, busy, inst, strb, bsy);
    end
  endtask

  task automatic test_reset();
    logic [27:0] g, j;
    g = mk(10, 9, 1, 2);
    j = mk(1, 3, 5, 6);
    #1;
    total++;
    if (instruction !== 20'h0 || busy !== 1'b0 || fifo_count !== 5'd0 || in_ready !== 1'b1 || issue_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: got inst=%h busy=%b count=%0d ready=%b strobe=%b, want 0 0 0 1 0",
               instruction, busy, fifo_count, in_ready, issue_strobe);
    end
    tick();
    reset_n = 1'b1;
    run = 1'b1;
    in_valid = 1'b1; in_entry = g;
    tick();
    in_entry = mk(4, 2, 2, 2);
    tick();
    chk("reset_pre_issue", g[19:0], 1'b1, 1'b1);
    in_valid = 1'b1; in_entry = mk(4, 7, 7, 7);
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (instruction !== 20'h0 || busy !== 1'b0 || fifo_count !== 5'd0 || in_ready !== 1'b1 || issue_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got inst=%h busy=%b count=%0d ready=%b strobe=%b, want 0 0 0 1 0",
               instruction, busy, fifo_count, in_ready, issue_strobe);
    end
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("reset_stays_idle", 20'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_entry = j;
    tick();
    in_valid = 1'b0;
    tick();
    chk("reset_after_issue", j[19:0], 1'b1, 1'b1);
    tick();
    chk("reset_after_idle", 20'h0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_seq();
    logic [27:0] a, b;
    a = mk(3, 3, 0, 2);
    b = mk(1, 5, 4, 0);
    run = 1'b1;
    in_valid = 1'b1; in_entry = a;
    tick();
    in_entry = b;
    tick();
    in_valid = 1'b0;
    chk("hold_a_c1", a[19:0], 1'b1, 1'b1);
    total++;
    if (fifo_count !== 5'd1) begin
      bad++;
      $display("FAIL hold_count: got %0d want 1", fifo_count);
    end
    tick();
    chk("hold_a_c2", a[19:0], 1'b0, 1'b1);
    tick();
    chk("hold_a_c3", a[19:0], 1'b0, 1'b1);
    tick();
    chk("hold_b_c1", b[19:0], 1'b1, 1'b1);
    tick();
    chk("hold_idle", 20'h0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_zero();
    logic [27:0] c;
    c = mk(0, 4, 0, 7);
    in_valid = 1'b1; in_entry = c;
    tick();
    in_valid = 1'b0;
    tick();
    chk("hold0_issue", c[19:0], 1'b1, 1'b1);
    tick();
    chk("hold0_idle", 20'h0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    logic [27:0] e [16];
    run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e[i] = mk(1, i, i + 1, 16 + i);
      in_valid = 1'b1; in_entry = e[i];
      tick();
    end
    total++;
    if (in_ready !== 1'b0 || fifo_count !== 5'd16) begin
      bad++;
      $display("FAIL full_state: got ready=%b count=%0d want 0 16", in_ready, fifo_count);
    end
    in_entry = mk(1, 15, 8'hAA, 8'hAA);
    tick();
    total++;
    if (fifo_count !== 5'd16 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_17th: got count=%0d busy=%b want 16 0", fifo_count, busy);
    end
    in_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("full_issue_%0d", i), e[i][19:0], 1'b1, 1'b1);
      if (i == 0) begin
        total++;
        if (in_ready !== 1'b1 || fifo_count !== 5'd15) begin
          bad++;
          $display("FAIL full_ready: got ready=%b count=%0d want 1 15", in_ready, fifo_count);
        end
      end
    end
    tick();
    chk("full_idle", 20'h0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL full_empty: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_pause();
    logic [27:0] d, e, f;
    d = mk(5, 6, 1, 1);
    e = mk(2, 7, 2, 2);
    f = mk(1, 8, 3, 3);
    run = 1'b1;
    in_valid = 1'b1; in_entry = d;
    tick();
    in_entry = e;
    tick();
    chk("pause_d1", d[19:0], 1'b1, 1'b1);
    in_entry = f;
    tick();
    in_valid = 1'b0;
    run = 1'b0;
    chk("pause_d2", d[19:0], 1'b0, 1'b1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk($sformatf("pause_d%0d", i), d[19:0], 1'b0, 1'b1);
    end
    tick();
    chk("pause_idle", 20'h0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 5'd2) begin
      bad++;
      $display("FAIL pause_kept: got %0d want 2", fifo_count);
    end
    tick();
    chk("pause_idle2", 20'h0, 1'b0, 1'b0);
    run = 1'b1;
    tick();
    chk("pause_e1", e[19:0], 1'b1, 1'b1);
    tick();
    chk("pause_e2", e[19:0], 1'b0, 1'b1);
    tick();
    chk("pause_f1", f[19:0], 1'b1, 1'b1);
    tick();
    chk("pause_end", 20'h0, 1'b0, 1'b0);
  endtask

`ifdef ISSUE_CNT_EN
  task automatic issue_n(input int n);
    int budget;
    run = 1'b1;
    in_entry = mk(1, 1, 1, 1);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    in_valid = 1'b0;
    budget = 40;
    tick();
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cnt_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_issue_cnt();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++;
    if (issued_cnt !== 16'd0) begin
      bad++;
      $display("FAIL cnt_reset: got %0d want 0", issued_cnt);
    end
    issue_n(3);
    total++;
    if (issued_cnt !== 16'd3) begin
      bad++;
      $display("FAIL cnt_three: got %0d want 3", issued_cnt);
    end
    issue_n(65532);
    total++;
    if (issued_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_max: got %h want ffff", issued_cnt);
    end
    issue_n(1);
    total++;
    if (issued_cnt !== 16'd0) begin
      bad++;
      $display("FAIL cnt_wrap: got %h want 0000", issued_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold_seq();
    test_hold_zero();
    test_full();
    test_pause();
`ifdef ISSUE_CNT_EN
    test_issue_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_issuer.md
# inst_issuer

Instruction issuer that feeds the CONTROL_UNIT `instruction` port, so software no longer has to drive it cycle by cycle. The host pushes entries into an internal FIFO; each entry holds one instruction and a hold count. The block presents each instruction to the control unit for exactly its hold count, then moves straight to the next entry. With nothing queued, or when paused, it drives the IDLE instruction.

## Interface
- OPCODE_BITS, 4, opcode field width
- ADDR_BITS, 8, width of ADDRA and of ADDRB
- HOLD_BITS, 8, hold-count field width
- DEPTH, 16, FIFO entries; power of two, ≥2
- IDLE_OPCODE, 0, opcode driven when nothing is issuing
- Derived: INST_BITS = OPCODE_BITS+2*ADDR_BITS (20); ENTRY_BITS = HOLD_BITS+INST_BITS (28)
- Instruction layout: [INST_BITS-1 -: OPCODE_BITS] opcode, then ADDRA, then ADDRB in the low ADDR_BITS. Entry layout: {hold, instruction}.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `reset_n`.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  issue enable; 0 pauses at the next instruction boundary
- in_valid  in  1  host entry valid
- in_entry  in  ENTRY_BITS  host entry {hold, opcode, addra, addrb}
- in_ready  out  1  FIFO can accept; equals (count < DEPTH)
- instruction  out  INST_BITS  registered instruction to the control unit
- issue_strobe  out  1  high during the first cycle each new instruction is presented
- busy  out  1  high while in ISSUE
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- issued_cnt  out  16  instructions issued; present only with ISSUE_CNT_EN

## Operation
- FIFO:
  - A push happens on a rising edge with in_valid && in_ready.
  - Full blocks the push; there is no pass-through path.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE and ISSUE.
- IDLE:
  - instruction = {IDLE_OPCODE, 0, 0}.
  - If run && count>0, pop the head, load the instruction register, load hold_ctr = max(hold,1)-1, assert issue_strobe, and go to ISSUE.
- ISSUE:
  - While hold_ctr>0, decrement it and keep the instruction unchanged.
  - When hold_ctr==0 (last cycle):
    - If run && count>0, pop the next entry back-to-back with no idle gap and stay in ISSUE.
    - Otherwise, go to IDLE and load the idle instruction.
- A hold of 0 is treated as 1.
- Each entry is presented for exactly max(hold,1) cycles.
- Deasserting run never truncates the current instruction; it takes effect only at the boundary.
- An entry pushed on the same edge the FIFO goes empty is not visible to that edge's pop decision. It issues on the next edge.

## Timing
- All outputs except in_ready are registered. in_ready is combinational from the count register.
- Reset values:
  - instruction = 0 ({IDLE_OPCODE,0,0} with default IDLE_OPCODE)
  - issue_strobe=0, busy=0, fifo_count=0, in_ready=1, issued_cnt=0
  - FSM in IDLE, FIFO emptied
- Reset mid-issue aborts the instruction and discards all queued entries.
- Latency: an entry pushed into an empty FIFO with run=1 at edge N appears on instruction after edge N+1.
- Back-to-back entries produce contiguous instructions with no gaps.
- The full-to-ready transition is visible the cycle after the pop.

## Configuration
- ISSUE_CNT_EN defined:
  - The 16-bit issued_cnt port exists.
  - It increments on every issue_strobe, wraps 0xFFFF→0, and is cleared by reset.
- ISSUE_CNT_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold reset_n low mid-stream → instruction=0, busy=0, fifo_count=0, in_ready=1. The next entry after release issues normally.
- Hold sequence: push {hold=3,op=3,A=0,B=2} then {hold=1,op=5,A=4,B=0} with run=1 → op3 for exactly 3 cycles, then op5 for 1 cycle, then idle. issue_strobe pulses twice with no gap between them.
- Hold=0: push {hold=0,op=4,A=0,B=7} → presented exactly 1 cycle.
- Full: push 16 entries with run=0 → in_ready=0, fifo_count=16, and a 17th valid is ignored. Setting run=1 then issues all 16 in order; in_ready returns to 1 the cycle after the first pop.
- Pause: drop run during a hold=5 instruction → it completes all 5 cycles, then idles with remaining entries kept. Raising run resumes issue one cycle later.
- ISSUE_CNT_EN: issue 3 entries → issued_cnt=3. Preload the counter to 0xFFFF and issue one entry → issued_cnt=0.
